// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the EX-stage branch resolver: FSM states and
// the bit positions of the one-hot branch opcode.
package branch_resolver_pkg;

   localparam int OP_WIDTH = 6;

   // One-hot br_op bit positions: {bgeu,bltu,bge,blt,bne,beq}
   localparam int OP_BEQ  = 0;
   localparam int OP_BNE  = 1;
   localparam int OP_BLT  = 2;
   localparam int OP_BGE  = 3;
   localparam int OP_BLTU = 4;
   localparam int OP_BGEU = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_SHADOW = 2'd2
   } br_state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// EX-stage operands in, flush/redirect and rollback bundle out.
// master = pipeline side, slave = resolver.
interface branch_resolver_if
   import branch_resolver_pkg::*;
#(
   parameter int CNT_WIDTH = 32
);
   logic                 PL_stall;
   logic                 B_type_ex;
   logic [OP_WIDTH-1:0]  br_op_ex;
   logic [31:0]          rs1_data;
   logic [31:0]          rs2_data;
   logic [31:0]          pc_ex;
   logic [31:0]          imme_ex;
   logic                 prediction_ex;
   logic                 jalr_ex;
   logic [31:0]          jalr_target;
   logic [31:0]          jalr_pc_prediction_ex;

   logic                 corrected_result;
   logic                 PL_flush;
   logic [31:0]          redirect_pc;
   logic                 B_type_branch_failed;
   logic [OP_WIDTH-1:0]  br_op_branch_failed;
   logic [31:0]          pc_branch_failed;
   logic                 B_type_result_branch_failed;
   logic                 ras_rollback_pop;
   logic [CNT_WIDTH-1:0] branch_count;
   logic [CNT_WIDTH-1:0] mispredict_count;

   modport master (
      output PL_stall, B_type_ex, br_op_ex, rs1_data, rs2_data, pc_ex, imme_ex,
             prediction_ex, jalr_ex, jalr_target, jalr_pc_prediction_ex,
      input  corrected_result, PL_flush, redirect_pc, B_type_branch_failed,
             br_op_branch_failed, pc_branch_failed, B_type_result_branch_failed,
             ras_rollback_pop, branch_count, mispredict_count
   );

   modport slave (
      input  PL_stall, B_type_ex, br_op_ex, rs1_data, rs2_data, pc_ex, imme_ex,
             prediction_ex, jalr_ex, jalr_target, jalr_pc_prediction_ex,
      output corrected_result, PL_flush, redirect_pc, B_type_branch_failed,
             br_op_branch_failed, pc_branch_failed, B_type_result_branch_failed,
             ras_rollback_pop, branch_count, mispredict_count
   );

endinterface

// File: rtl/branch_resolver_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   // Count up on inc_i, clear on clr_i, hold once all-ones is reached
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: evaluates B-type outcomes and jalr targets,
// raises a one-cycle registered flush/redirect plus the rollback bundle
// on a mispredict, then ignores wrong-path EX contents for a shadow window.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int CNT_WIDTH     = 32,
   parameter int SHADOW_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   branch_resolver_if.slave  br
);

   localparam int SH_W = (SHADOW_CYCLES > 2) ? $clog2(SHADOW_CYCLES) : 1;
   localparam logic [SH_W-1:0] SH_INIT = SH_W'((SHADOW_CYCLES > 1) ? SHADOW_CYCLES - 1 : 0);

   br_state_e           state_q, state_d;
   logic [SH_W-1:0]     shadow_q, shadow_d;
   logic                flush_q, flush_d;
   logic [31:0]         redirect_q, redirect_d;
   logic                btype_fail_q, btype_fail_d;
   logic [OP_WIDTH-1:0] op_fail_q, op_fail_d;
   logic [31:0]         pc_fail_q, pc_fail_d;
   logic                res_fail_q, res_fail_d;
   logic                ras_pop_q, ras_pop_d;

   logic                eq, lt_s, lt_u;
   logic [OP_WIDTH-1:0] outcome_vec;
   logic                result;
   logic                acc, mp_b, mp_j;

   assign eq   = (br.rs1_data == br.rs2_data);
   assign lt_s = ($signed(br.rs1_data) < $signed(br.rs2_data));
   assign lt_u = (br.rs1_data < br.rs2_data);

   // Per-opcode outcome, selected by the one-hot opcode (zero opcode -> not taken)
   always_comb begin
      outcome_vec          = '0;
      outcome_vec[OP_BEQ]  = eq;
      outcome_vec[OP_BNE]  = !eq;
      outcome_vec[OP_BLT]  = lt_s;
      outcome_vec[OP_BGE]  = !lt_s;
      outcome_vec[OP_BLTU] = lt_u;
      outcome_vec[OP_BGEU] = !lt_u;
      result = br.B_type_ex && (|(outcome_vec & br.br_op_ex));
   end

   assign acc  = !br.PL_stall && (state_q == ST_IDLE);
   assign mp_b = acc && br.B_type_ex && (result != br.prediction_ex);
   assign mp_j = acc && br.jalr_ex && !br.B_type_ex &&
                 (br.jalr_target != br.jalr_pc_prediction_ex);

   // Next state and rollback bundle; the bundle defaults to zero so it lives one cycle
   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      flush_d      = 1'b0;
      redirect_d   = redirect_q;
      btype_fail_d = 1'b0;
      op_fail_d    = '0;
      pc_fail_d    = '0;
      res_fail_d   = 1'b0;
      ras_pop_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mp_b || mp_j) begin
               state_d      = ST_FLUSH;
               flush_d      = 1'b1;
               if (mp_b) begin
                  redirect_d = result ? (br.pc_ex + br.imme_ex) : (br.pc_ex + 32'd4);
               end else begin
                  redirect_d = br.jalr_target;
               end
               btype_fail_d = mp_b;
               op_fail_d    = mp_b ? br.br_op_ex : '0;
               pc_fail_d    = br.pc_ex;
               res_fail_d   = result;
               ras_pop_d    = mp_j;
            end
         end
         ST_FLUSH: begin
            if (SHADOW_CYCLES <= 1) begin
               state_d = ST_IDLE;
            end else begin
               state_d  = ST_SHADOW;
               shadow_d = SH_INIT;
            end
         end
         ST_SHADOW: begin
            if (shadow_q == '0) begin
               state_d = ST_IDLE;
            end else if (!br.PL_stall) begin
               shadow_d = shadow_q - SH_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, shadow counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shadow_q     <= '0;
         flush_q      <= 1'b0;
         redirect_q   <= '0;
         btype_fail_q <= 1'b0;
         op_fail_q    <= '0;
         pc_fail_q    <= '0;
         res_fail_q   <= 1'b0;
         ras_pop_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         flush_q      <= flush_d;
         redirect_q   <= redirect_d;
         btype_fail_q <= btype_fail_d;
         op_fail_q    <= op_fail_d;
         pc_fail_q    <= pc_fail_d;
         res_fail_q   <= res_fail_d;
         ras_pop_q    <= ras_pop_d;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (acc && (br.B_type_ex || br.jalr_ex)),
      .clr_i   (1'b0),
      .count_o (br.branch_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (mp_b || mp_j),
      .clr_i   (1'b0),
      .count_o (br.mispredict_count)
   );

   assign br.corrected_result            = result;
   assign br.PL_flush                    = flush_q;
   assign br.redirect_pc                 = redirect_q;
   assign br.B_type_branch_failed        = btype_fail_q;
   assign br.br_op_branch_failed         = op_fail_q;
   assign br.pc_branch_failed            = pc_fail_q;
   assign br.B_type_result_branch_failed = res_fail_q;
   assign br.ras_rollback_pop            = ras_pop_q;

endmodule
